// File: rtl/fp_round_pipe_pkg.sv
// Shared types and constants for the single-precision round/pack pipeline.
package fp_round_pipe_pkg;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  localparam logic [31:0] NAN_CANON = 32'h7FC00000;

  typedef struct packed {
    logic        sig;
    logic [10:0] expo;
    logic [24:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        diff;
  } fp_rnd_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_rnd_out_type;

  // Stage 1 holds the raw operand; rounding happens between stage 1 and stage 2.
  typedef fp_rnd_in_type fp_round_reg_type_1;

  typedef struct packed {
    logic        sig;
    logic [10:0] expo;
    logic [23:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic        nx;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        diff;
  } fp_round_reg_type_2;

  localparam fp_round_reg_type_1 init_fp_round_reg_1 = '0;
  localparam fp_round_reg_type_2 init_fp_round_reg_2 = '0;

endpackage

// File: rtl/fp_round_pipe.sv
// Two-stage rounding and packing pipeline: increment/normalise, then exceptions and packing.
module fp_round_pipe
  import fp_round_pipe_pkg::*;
(
  input  logic          reset,
  input  logic          clock,
  input  fp_rnd_in_type fp_rnd_i,
  input  logic          valid_i,
  input  logic          clear,
  output logic [31:0]   result,
  output logic [4:0]    flags,
  output logic          ready
);

  fp_round_reg_type_1 r1;
  fp_round_reg_type_2 r2;
  fp_round_reg_type_2 r2_next;
  fp_rnd_out_type     out_reg;
  logic               v1;
  logic               v2;

  logic        inc;
  logic        any_grs;
  logic [24:0] mant_sum;
  logic [10:0] expo_adj;

  always_comb begin
    any_grs = |r1.grs;
    case (r1.rm)
      RTZ:     inc = 1'b0;
      RDN:     inc = r1.sig & any_grs;
      RUP:     inc = ~r1.sig & any_grs;
      RMM:     inc = r1.grs[2];
      default: inc = r1.grs[2] & (r1.grs[1] | r1.grs[0] | r1.mant[0]);
    endcase

    mant_sum = r1.mant + {24'd0, inc};
    expo_adj = r1.expo;
    if (mant_sum[24]) begin
      mant_sum = mant_sum >> 1;
      expo_adj = expo_adj + 11'd1;
    end
    // A subnormal that rounds up into the hidden bit becomes the smallest normal.
    if (expo_adj == 11'd0 && mant_sum[23])
      expo_adj = 11'd1;

    r2_next      = init_fp_round_reg_2;
    r2_next.sig  = r1.sig;
    r2_next.expo = expo_adj;
    r2_next.mant = mant_sum[23:0];
    r2_next.rema = r1.rema;
    r2_next.fmt  = r1.fmt;
    r2_next.rm   = r1.rm;
    r2_next.nx   = any_grs;
    r2_next.snan = r1.snan;
    r2_next.qnan = r1.qnan;
    r2_next.dbz  = r1.dbz;
    r2_next.inf  = r1.inf;
    r2_next.zero = r1.zero;
    r2_next.diff = r1.diff;
  end

  logic        ovf;
  logic        ovf_to_inf;
  logic        zero_sign;
  logic [31:0] result_next;
  logic [4:0]  flags_next;

  always_comb begin
    ovf        = r2.expo >= 11'd255;
    ovf_to_inf = 1'b1;
    case (r2.rm)
      RTZ:     ovf_to_inf = 1'b0;
      RDN:     ovf_to_inf = r2.sig;
      RUP:     ovf_to_inf = ~r2.sig;
      default: ovf_to_inf = 1'b1;
    endcase
    zero_sign = r2.diff ? (r2.rm == RDN) : r2.sig;

    result_next = {r2.sig, r2.expo[7:0], r2.mant[22:0]};
    flags_next  = {3'b000, r2.nx & (r2.expo == 11'd0), r2.nx};
    if (r2.snan) begin
      result_next = NAN_CANON;
      flags_next  = 5'b10000;
    end else if (r2.qnan) begin
      result_next = NAN_CANON;
      flags_next  = 5'b00000;
    end else if (r2.dbz) begin
      result_next = {r2.sig, 31'h7F800000};
      flags_next  = 5'b01000;
    end else if (r2.inf) begin
      result_next = {r2.sig, 8'hFF, 23'h0};
      flags_next  = 5'b00000;
    end else if (r2.zero) begin
      result_next = {zero_sign, 31'h0};
      flags_next  = 5'b00000;
    end else if (ovf) begin
      result_next = ovf_to_inf ? {r2.sig, 8'hFF, 23'h0} : {r2.sig, 31'h7F7FFFFF};
      flags_next  = 5'b00101;
    end
  end

  // fmt/rema travel with the operand but do not affect the packed result.
  logic unused_fields;
  assign unused_fields = ^{r2.fmt, r2.rema, r2.mant[23]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1      <= init_fp_round_reg_1;
      r2      <= init_fp_round_reg_2;
      v1      <= 1'b0;
      v2      <= 1'b0;
      out_reg <= '0;
    end else begin
      v1            <= valid_i & ~clear;
      v2            <= v1 & ~clear;
      out_reg.ready <= v2 & ~clear;
      if (valid_i)
        r1 <= fp_rnd_i;
      if (v1)
        r2 <= r2_next;
      if (v2 & ~clear) begin
        out_reg.result <= result_next;
        out_reg.flags  <= flags_next;
      end
    end
  end

  assign result = out_reg.result;
  assign flags  = out_reg.flags;
  assign ready  = out_reg.ready;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed-vector bench for fp_round_pipe: rounding cases, specials, pipelining, clear and reset.
module tb_fp_round_pipe;
  import fp_round_pipe_pkg::*;

  logic          reset;
  logic          clock;
  fp_rnd_in_type fp_rnd_i;
  logic          valid_i;
  logic          clear;
  logic [31:0]   result;
  logic [4:0]    flags;
  logic          ready;

  int tests_run = 0;
  int tests_failed = 0;

  fp_round_pipe dut (
    .reset    (reset),
    .clock    (clock),
    .fp_rnd_i (fp_rnd_i),
    .valid_i  (valid_i),
    .clear    (clear),
    .result   (result),
    .flags    (flags),
    .ready    (ready)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic fp_rnd_in_type mk(input logic s, input logic [10:0] e, input logic [24:0] m,
                                       input logic [2:0] g, input logic [2:0] rmode);
    fp_rnd_in_type op;
    op      = '0;
    op.sig  = s;
    op.expo = e;
    op.mant = m;
    op.grs  = g;
    op.rm   = rmode;
    op.fmt  = 2'b11;
    op.rema = 2'b10;
    return op;
  endfunction

  // Issue one operation and require ready exactly 2 cycles after acceptance.
  task automatic run_op(input string tag, input fp_rnd_in_type op,
                        input logic [31:0] exp_res, input logic [4:0] exp_flags);
    int k;
    @(negedge clock);
    fp_rnd_i = op;
    valid_i  = 1'b1;
    @(negedge clock);
    valid_i  = 1'b0;
    fp_rnd_i = '0;
    k = 1;
    while (k <= 6) begin
      @(negedge clock);
      if (ready) break;
      k++;
    end
    check({tag, " latency"}, k, 2);
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, {27'd0, flags}, {27'd0, exp_flags});
  endtask

  task automatic count_ready(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (ready) n++;
    end
  endtask

  fp_rnd_in_type op;
  int            n;

  initial begin
    reset    = 1'b0;
    valid_i  = 1'b0;
    clear    = 1'b0;
    fp_rnd_i = '0;
    #12;
    check("reset result", result, 32'h0);
    check("reset flags", {27'd0, flags}, 32'h0);
    check("reset ready", {31'd0, ready}, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    // Rounding
    run_op("rne tie odd", mk(0, 127, 25'h800001, 3'b100, RNE), 32'h3F800002, 5'b00001);
    run_op("rne tie even", mk(0, 127, 25'h800000, 3'b100, RNE), 32'h3F800000, 5'b00001);
    run_op("carry out", mk(0, 127, 25'hFFFFFF, 3'b110, RNE), 32'h40000000, 5'b00001);
    run_op("rmm half", mk(0, 127, 25'h800000, 3'b100, RMM), 32'h3F800001, 5'b00001);
    run_op("rtz trunc", mk(0, 127, 25'h800000, 3'b111, RTZ), 32'h3F800000, 5'b00001);
    run_op("mode 7 rne", mk(0, 127, 25'h800001, 3'b100, 3'd7), 32'h3F800002, 5'b00001);
    run_op("exact", mk(1, 130, 25'hC00000, 3'b000, RUP), 32'hC1400000, 5'b00000);

    // Overflow
    run_op("ovf rup neg", mk(1, 254, 25'hFFFFFF, 3'b001, RUP), 32'hFF7FFFFF, 5'b00001);
    run_op("ovf rdn neg", mk(1, 254, 25'hFFFFFF, 3'b001, RDN), 32'hFF800000, 5'b00101);
    run_op("ovf rtz pos", mk(0, 255, 25'h800000, 3'b000, RTZ), 32'h7F7FFFFF, 5'b00101);
    run_op("ovf rne big", mk(0, 300, 25'h800000, 3'b000, RNE), 32'h7F800000, 5'b00101);

    // Specials
    op = mk(0, 0, 0, 3'b111, RNE); op.snan = 1'b1; op.dbz = 1'b1;
    run_op("snan", op, 32'h7FC00000, 5'b10000);
    op = mk(1, 0, 0, 3'b111, RNE); op.qnan = 1'b1; op.inf = 1'b1;
    run_op("qnan", op, 32'h7FC00000, 5'b00000);
    op = mk(0, 0, 0, 3'b000, RNE); op.dbz = 1'b1;
    run_op("dbz", op, 32'h7F800000, 5'b01000);
    op = mk(1, 0, 0, 3'b101, RNE); op.inf = 1'b1;
    run_op("inf neg", op, 32'hFF800000, 5'b00000);
    op = mk(0, 0, 0, 3'b000, RDN); op.zero = 1'b1; op.diff = 1'b1;
    run_op("zero diff rdn", op, 32'h80000000, 5'b00000);
    op = mk(1, 0, 0, 3'b000, RNE); op.zero = 1'b1; op.diff = 1'b1;
    run_op("zero diff rne", op, 32'h00000000, 5'b00000);
    op = mk(1, 0, 0, 3'b000, RUP); op.zero = 1'b1;
    run_op("zero neg", op, 32'h80000000, 5'b00000);

    // Subnormals
    run_op("subn promote", mk(0, 0, 25'h7FFFFF, 3'b100, RNE), 32'h00800000, 5'b00001);
    run_op("subn uf", mk(0, 0, 25'h000001, 3'b010, RNE), 32'h00000001, 5'b00011);

    // Three back-to-back operations
    @(negedge clock);
    fp_rnd_i = mk(0, 127, 25'h800000, 3'b000, RNE); valid_i = 1'b1;
    @(negedge clock);
    fp_rnd_i = mk(0, 128, 25'h800000, 3'b000, RNE);
    @(negedge clock);
    fp_rnd_i = mk(1, 129, 25'h800000, 3'b000, RNE);
    @(negedge clock);
    valid_i = 1'b0;
    check("b2b ready 0", {31'd0, ready}, 32'h1);
    check("b2b result 0", result, 32'h3F800000);
    @(negedge clock);
    check("b2b ready 1", {31'd0, ready}, 32'h1);
    check("b2b result 1", result, 32'h40000000);
    @(negedge clock);
    check("b2b ready 2", {31'd0, ready}, 32'h1);
    check("b2b result 2", result, 32'hC0800000);
    @(negedge clock);
    check("b2b ready end", {31'd0, ready}, 32'h0);
    check("b2b hold", result, 32'hC0800000);

    // Clear one cycle after the valid kills it
    @(negedge clock);
    fp_rnd_i = mk(0, 127, 25'h800001, 3'b100, RNE); valid_i = 1'b1;
    @(negedge clock);
    valid_i = 1'b0; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    count_ready(5, n);
    check("clear flush readies", n, 0);
    check("clear hold result", result, 32'hC0800000);

    // Clear coincident with valid drops the new operation
    @(negedge clock);
    fp_rnd_i = mk(0, 127, 25'h800001, 3'b100, RNE); valid_i = 1'b1; clear = 1'b1;
    @(negedge clock);
    valid_i = 1'b0; clear = 1'b0;
    count_ready(5, n);
    check("clear same edge readies", n, 0);

    // Asynchronous reset while one result is presented and another is in flight
    @(negedge clock);
    fp_rnd_i = mk(0, 127, 25'h800001, 3'b100, RNE); valid_i = 1'b1;
    @(negedge clock);
    fp_rnd_i = mk(0, 128, 25'h800001, 3'b100, RNE);
    @(negedge clock);
    valid_i = 1'b0;
    @(negedge clock);
    check("pre-reset ready", {31'd0, ready}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async reset ready", {31'd0, ready}, 32'h0);
    check("async reset result", result, 32'h0);
    check("async reset flags", {27'd0, flags}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    count_ready(5, n);
    check("post-reset stale", n, 0);
    run_op("post-reset op", mk(0, 127, 25'hFFFFFF, 3'b110, RNE), 32'h40000000, 5'b00001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
# fp_round_pipe

Two-stage pipelined rounding and packing unit for single-precision results. It consumes the `fp_rnd` bundle and `ready` strobe produced by the FMA datapath, plus the same bundle from the other FP arithmetic units, which are muxed upstream. It applies the IEEE-754 rounding mode, handles carry-out, overflow and underflow, and resolves special cases. It then drives a packed 32-bit result with RISC-V fflags to the FPU writeback mux.

## Interface
Parameters: none (single precision only).

Ports:
- `reset` input 1: asynchronous, active-low reset.
- `clock` input 1: rising-edge clock.
- `fp_rnd_i` input `fp_rnd_in_type`, with fields:
  - `sig` 1
  - `expo` 11, unsigned, ≥0
  - `mant` 25: bit 24 is zero, bit 23 is the hidden bit
  - `rema` 2
  - `fmt` 2
  - `rm` 3
  - `grs` 3
  - `snan`, `qnan`, `dbz`, `inf`, `zero`, `diff`
- `valid_i` input 1: `fp_rnd_i` is valid this cycle. Connected to the upstream `ready`.
- `clear` input 1: synchronous flush of in-flight operations.
- `result` output 32: packed single-precision result.
- `flags` output 5: {NV, DZ, OF, UF, NX}.
- `ready` output 1: `result`/`flags` are valid this cycle.

## Operation
- `rm` encoding:
  - 0 = RNE, 1 = RTZ, 2 = RDN, 3 = RUP, 4 = RMM.
  - 5–7 behave as RNE.
- `fmt` and `rema` are carried through the pipeline and ignored.
- Stage 1 (rounding increment). Let g, r, s = `grs[2:0]` and lsb = `mant[0]`. The increment `inc` is:
  - RNE: g&(r|s|lsb)
  - RTZ: 0
  - RDN: sig&(g|r|s)
  - RUP: ~sig&(g|r|s)
  - RMM: g
- Stage 1 datapath:
  - mant_r = mant + inc (25-bit).
  - NX = |grs.
  - Carry-out: if `mant_r[24]`, then mant_r >>= 1 and expo += 1.
  - Subnormal promotion: if expo==0 and `mant_r[23]`, then expo = 1.
- Stage 2 (exceptions and packing). Priority is highest first:
  1. `snan`: result 0x7FC00000, NV=1, other flags 0.
  2. `qnan`: result 0x7FC00000, all flags 0.
  3. `dbz`: result {sig, 0x7F800000[30:0]}, DZ=1.
  4. `inf`: result {sig, 8'hFF, 23'h0}, flags 0.
  5. `zero`: result {z, 31'h0}, flags 0. z = (rm==RDN) when `diff`, otherwise `sig`.
  6. Overflow (expo ≥ 255): OF=1, NX=1. Result is ±inf for RNE/RMM, for RUP with sig=0, and for RDN with sig=1. Otherwise it is ±0x7F7FFFFF (max finite).
  7. Normal/subnormal: result {sig, expo[7:0], mant_r[22:0]}. UF = NX & (expo==0).
- Arithmetic widths:
  - The exponent is held at 11 bits throughout, so there is no wrap.
  - The exponent increment from carry-out is applied before the overflow compare.

## Timing
- Latency is 2 cycles. A `valid_i` sampled at edge N gives `ready`=1 in the cycle after edge N+2.
- Throughput is 1 operation per cycle with no backpressure. Back-to-back operations complete in order.
- `ready` is high for exactly one cycle per accepted operation.
- `result` and `flags` hold their last value while `ready`=0.
- `clear`=1 at an edge zeroes both stage valid bits at that edge:
  - Nothing in flight completes.
  - A `valid_i` sampled at the same edge is dropped; `clear` wins.
- Reset:
  - Values: `result`=0, `flags`=0, `ready`=0, and all stage valid bits 0.
  - Reset takes effect immediately on the falling edge of `reset`, even mid-operation.
  - The first operation accepted after reset release completes normally at the 2-cycle latency.
- Stage registers load only when their incoming valid is 1 and gate nothing else. No state machine is needed beyond the 2-deep valid shift.

## Structure
- `fp_wire` additions:
  - `fp_rnd_out_type` {result, flags, ready}.
  - `fp_round_reg_type_1` and `fp_round_reg_type_2`.
  - `init_fp_round_reg_1` and `init_fp_round_reg_2`.
  - Rounding-mode localparams RNE/RTZ/RDN/RUP/RMM.
  - The canonical NaN constant 0x7FC00000.
- No sub-module: the increment logic is a small combinational block inside stage 1.

## Test plan
- RNE tie-to-even, expo=127, grs=100:
  - mant=0x800001 → 0x3F800002, NX.
  - mant=0x800000 → 0x3F800000, NX.
- Carry-out: expo=127, mant=0xFFFFFF, grs=110, RNE → 0x40000000, flags=00001.
- Overflow directed, sig=1, expo=254, mant=0xFFFFFF, grs=001:
  - RUP → 0xFF7FFFFF, NX only.
  - RDN → 0xFF800000, OF|NX.
- Specials:
  - `snan` → 0x7FC00000, flags=10000.
  - `zero` with `diff`=1, rm=RDN → 0x80000000, flags=0.
  - `dbz`, sig=0 → 0x7F800000, flags=01000.
- Subnormals with expo=0:
  - mant=0x7FFFFF, grs=100, RNE → 0x00800000, NX, UF=0.
  - mant=0x000001, grs=010, RNE → 0x00000001, NX|UF.
- Pipeline and control:
  - Three consecutive `valid_i` → `ready` high for three consecutive cycles, in order.
  - `clear` one cycle after the first valid → no `ready` for the first operation.
  - `reset` low mid-flight → `ready`, `result` and `flags` all 0 immediately, and no stale completion after reset release.
